// File: rtl/nor_gate_pkg.sv
// Shared constants and the NOR helper used by the nor_gate_unit slice.
package nor_gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;
    // Widest operand the helper accepts; callers zero-extend into it.
    localparam int NOR_MAX_W = 256;

    function automatic logic [NOR_MAX_W-1:0] nor_vec(
        input logic [NOR_MAX_W-1:0] a,
        input logic [NOR_MAX_W-1:0] b
    );
        return ~(a | b);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/nor_gate_unit.sv
// Bitwise NOR leaf cell: pure combinational output plus a registered copy
// with valid flag and a saturating count of all-ones results.
module nor_gate_unit
    import nor_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] hi_count,
    input  logic             clr_count
);

    logic [NOR_MAX_W-1:0] w_nor_full;
    logic [WIDTH-1:0]     w_nor;
    logic                 w_all_ones;
    logic                 w_hi_inc;
    logic [WIDTH-1:0]     r_c_q;
    logic                 r_out_valid;

    // Zero-extended operands make the upper result bits all ones, so the
    // full-width AND reduction equals the all-ones test on the WIDTH bits.
    assign w_nor_full = nor_vec(NOR_MAX_W'(a), NOR_MAX_W'(b));
    assign w_nor      = w_nor_full[WIDTH-1:0];
    assign w_all_ones = &w_nor_full;
    assign w_hi_inc   = in_valid & w_all_ones;

    assign c = w_nor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_c_q <= w_nor;
            end
        end
    end

    assign c_q       = r_c_q;
    assign out_valid = r_out_valid;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_hi_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_hi_inc),
        .clr  (clr_count),
        .count(hi_count)
    );

endmodule

// File: tb/tb_nor_gate_unit.sv
// Self-checking bench for nor_gate_unit: truth-table vectors, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_nor_gate_unit;

  typedef struct {
    logic a;
    logic b;
    logic exp_c;
  } comb_vec_t;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance with idle clock and reset held low: a pure gate.
  logic        clk_idle  = 1'b0;
  logic        rst_n1    = 1'b0;
  logic [0:0]  a1        = '0;
  logic [0:0]  b1        = '0;
  logic [0:0]  c1;
  logic [0:0]  c_q1;
  logic        ov1;
  logic [15:0] hi1;

  nor_gate_unit #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk_idle), .rst_n(rst_n1), .a(a1), .b(b1), .c(c1),
    .in_valid(1'b0), .c_q(c_q1), .out_valid(ov1), .hi_count(hi1),
    .clr_count(1'b0)
  );

  // WIDTH=4 instances sharing stimulus; one with a 2-bit counter for saturation.
  logic        rst_n    = 1'b0;
  logic [3:0]  a4       = '0;
  logic [3:0]  b4       = '0;
  logic        in_valid = 1'b0;
  logic        clr      = 1'b0;
  logic [3:0]  c4, c_q4, c4s, c_q4s;
  logic        ov4, ov4s;
  logic [15:0] hi16;
  logic [1:0]  hi2;

  nor_gate_unit #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4),
    .in_valid(in_valid), .c_q(c_q4), .out_valid(ov4), .hi_count(hi16),
    .clr_count(clr)
  );

  nor_gate_unit #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4s),
    .in_valid(in_valid), .c_q(c_q4s), .out_valid(ov4s), .hi_count(hi2),
    .clr_count(clr)
  );

  // ---------------- reference model ----------------
  int exp_cq  = 0;
  int exp_ov  = 0;
  int exp_h16 = 0;
  int exp_h2  = 0;

  function automatic int nor4(input int a, input int b);
    return 15 - (a | b);
  endfunction

  task automatic mdl_reset();
    exp_cq  = 0;
    exp_ov  = 0;
    exp_h16 = 0;
    exp_h2  = 0;
  endtask

  task automatic mdl_edge(input int v, input int a, input int b, input int c);
    int hit;
    hit = (v != 0) && (nor4(a, b) == 15);
    if (v != 0) exp_cq = nor4(a, b);
    exp_ov = v;
    if (c != 0) begin
      exp_h16 = 0;
      exp_h2  = 0;
    end else if (hit != 0) begin
      if (exp_h16 < 65535) exp_h16 = exp_h16 + 1;
      if (exp_h2 < 3)      exp_h2  = exp_h2 + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".c_q"},       32'(c_q4),  32'(exp_cq));
    chk({tag, ".out_valid"}, 32'(ov4),   32'(exp_ov));
    chk({tag, ".hi16"},      32'(hi16),  32'(exp_h16));
    chk({tag, ".c_q_sat"},   32'(c_q4s), 32'(exp_cq));
    chk({tag, ".ov_sat"},    32'(ov4s),  32'(exp_ov));
    chk({tag, ".hi2"},       32'(hi2),   32'(exp_h2));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; leaves time at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
    in_valid = v;
    a4       = a;
    b4       = b;
    clr      = c;
    #1;
    chk({tag, ".c"},     32'(c4),  32'(nor4(int'(a), int'(b))));
    chk({tag, ".c_sat"}, 32'(c4s), 32'(nor4(int'(a), int'(b))));
    @(posedge clk);
    mdl_edge(int'(v), int'(a), int'(b), int'(c));
    @(negedge clk);
    chk_regs(tag);
  endtask

  // ---------------- test ----------------
  comb_vec_t tt[4];

  initial begin
    tt[0] = '{a: 1'b0, b: 1'b0, exp_c: 1'b1};
    tt[1] = '{a: 1'b0, b: 1'b1, exp_c: 1'b0};
    tt[2] = '{a: 1'b1, b: 1'b0, exp_c: 1'b0};
    tt[3] = '{a: 1'b1, b: 1'b1, exp_c: 1'b0};

    // Combinational truth table on the unclocked instance.
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a;
      b1 = tt[i].b;
      #1;
      chk($sformatf("tt[%0d].c", i), 32'(c1), 32'(tt[i].exp_c));
      #4;
    end
    #10;
    chk("tt.c_final", 32'(c1), 32'(tt[3].exp_c));
    chk("tt.c_q_idle", 32'(c_q1), 32'd0);
    chk("tt.hi_idle", 32'(hi1), 32'd0);

    // Reset state of the clocked instances.
    @(negedge clk);
    mdl_reset();
    chk_regs("reset");
    rst_n = 1'b1;

    // Registered path: capture then hold.
    step("cap", 1'b1, 4'b0101, 4'b0011, 1'b0);
    chk("cap.c_q_const", 32'(c_q4), 32'h8);
    step("hold", 1'b0, 4'b1111, 4'b1111, 1'b0);
    chk("hold.c_q_const", 32'(c_q4), 32'h8);

    // Counter: four all-ones, one not, then clear wins over increment.
    for (int i = 0; i < 4; i++) step("ones", 1'b1, 4'b0000, 4'b0000, 1'b0);
    step("notones", 1'b1, 4'b0001, 4'b0000, 1'b0);
    chk("cnt.four", 32'(hi16), 32'd4);
    step("clrwin", 1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("cnt.cleared", 32'(hi16), 32'd0);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 6; i++) step("sat", 1'b1, 4'b0000, 4'b0000, 1'b0);
    chk("sat.hi2", 32'(hi2), 32'd3);
    chk("sat.hi16", 32'(hi16), 32'd6);

    // Async reset mid-operation.
    step("pre_clr", 1'b0, 4'b0000, 4'b0000, 1'b1);
    step("pre1", 1'b1, 4'b0000, 4'b0000, 1'b0);
    step("pre2", 1'b1, 4'b0000, 4'b0000, 1'b0);
    chk("pre.hi16", 32'(hi16), 32'd2);
    chk("pre.c_q", 32'(c_q4), 32'hF);
    a4 = 4'b0100;
    b4 = 4'b0010;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk_regs("arst");
    chk("arst.c", 32'(c4), 32'(nor4(4, 2)));
    @(posedge clk);
    @(negedge clk);
    chk_regs("arst_hold");
    rst_n = 1'b1;
    step("post", 1'b1, 4'b0101, 4'b0011, 1'b0);
    chk("post.c_q_const", 32'(c_q4), 32'h8);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) begin
        step("rnd0", 1'b1, 4'b0000, 4'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
